mem_group_requester: RTL and testbench
======================================

Name: mem_group_requester

Overview:
- Parametrised successor to the fixed k/l pair request path in the SMEM AFU core.
- Accepts a group of 1..LANES line addresses with a read-number tag and issues them as single reads on the TX_RD channel, throttled by almostfull.
- Steers the in-order RX_RD responses back into per-lane slots and presents one bundle per group with tag and lane mask.
- Replaces the odd/even tag toggling and the twin k/l response FIFOs with a credit-checked tracker that supports a variable lane count per group.

Parameters:
ADDR_WIDTH, 58, cache-line address width
DATA_WIDTH, 512, cache-line data width
LANES, 2, maximum addresses per group (>=1)
TAG_WIDTH, 6, read-number tag width (READ_NUM_WIDTH)
MAX_GROUPS, 8, maximum groups in flight (power of 2)

Ports:
CLK_400M  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush of all state
grp_valid  in  1  group offered
grp_ready  out  1  group accepted when grp_valid&grp_ready
grp_addr  in  LANES*ADDR_WIDTH  lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
grp_lanes  in  $clog2(LANES+1)  active lanes; 0 or >LANES is clamped to LANES
grp_tag  in  TAG_WIDTH  tag returned with the bundle
spl_tx_rd_almostfull  in  1  TX_RD backpressure
cor_tx_rd_valid  out  1  read request strobe
cor_tx_rd_addr  out  ADDR_WIDTH  read address
io_rx_rd_valid  in  1  response strobe; responses arrive in request order
io_rx_data  in  DATA_WIDTH  response line
out_valid  out  1  bundle valid, held until out_ready
out_ready  in  1  consumer accepts bundle
out_data  out  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]; inactive lanes zero
out_mask  out  LANES  bit i=1 for active lane i
out_tag  out  TAG_WIDTH  tag of the bundle
groups_inflight  out  $clog2(MAX_GROUPS+1)  accepted groups not yet consumed
err_overflow  out  1  sticky: response arrived with no pending lane

Behaviour:
- Reset (async, reset_n=0) or clear=1 (sync): all outputs 0, tracker and response FIFO empty, issue FSM in IDLE, err_overflow cleared.
- Tracker FIFO, depth MAX_GROUPS, holds {addrs, lanes, tag}.
  - grp_ready = (issue FSM in IDLE) & (groups_inflight < MAX_GROUPS) & !clear.
  - groups_inflight increments on accept and decrements on out_valid&out_ready; simultaneous accept and consume leaves it unchanged.
- Issue FSM:
  - IDLE: on accept, latch the group, set lane index li=0, go to ISSUE.
  - ISSUE: each cycle with spl_tx_rd_almostfull=0, register cor_tx_rd_valid=1 and cor_tx_rd_addr=addr[li], then li++. Cycles with almostfull=1 register valid=0 and leave li unchanged.
  - After the last active lane issues, return to IDLE. A new group is accepted no earlier than the cycle after that.
- Latency:
  - The first request is visible the cycle after acceptance.
  - With no stall, lanes issue on consecutive cycles.
  - Throughput: one group per lanes+1 cycles.
- Response FIFO, depth MAX_GROUPS*LANES: written on every io_rx_rd_valid and never backpressured. The credit check guarantees space.
  - A write when the FIFO is full, or when no read is outstanding (requests issued minus responses received = 0), sets err_overflow and the data is dropped.
- Assembler:
  - Pops one response per cycle into slot[ai] of the head tracker group while the bundle register is free.
  - When ai reaches the head group's lane count, it loads out_data/out_mask/out_tag and asserts out_valid on the next cycle, then pops the tracker.
  - Minimum latency from the last lane's io_rx_rd_valid to out_valid is 2 cycles.
  - While out_valid=1 and out_ready=0, the outputs are stable and assembly of the next group continues into the staging slots. It does not load the bundle register.
  - Back-to-back bundles are supported: out_valid stays high across consecutive groups.
- Tag and address values pass through unmodified; no arithmetic on addresses.
- clear with reads outstanding: internal state is flushed. Responses arriving later are treated as unexpected and set err_overflow. The block must never hang.

Test Plan:
- LANES=2, group addr0=0x100, addr1=0x200, lanes=2, tag=5, no stall -> requests 0x100 then 0x200 on consecutive cycles. Responses A, B give out_data={B,A}, out_mask=2'b11, out_tag=5, 2 cycles after B.
- lanes=1, addr0=0x40 -> one request only. out_mask=2'b01, upper lane data 0. lanes=0 -> treated as 2.
- almostfull high for 3 cycles after the first request -> second request delayed exactly 3 cycles, address unchanged, no duplicate.
- 8 groups accepted, out_ready=0 -> grp_ready=0 with groups_inflight=8. First out_ready -> groups_inflight=7, grp_ready=1 next cycle. Tags emerge in order 0..7.
- io_rx_rd_valid with nothing outstanding -> err_overflow=1 and stays 1 until reset/clear. Outputs are unchanged.
- reset_n asserted mid-ISSUE with out_valid=1 -> all outputs 0 immediately (async). After release, a fresh group completes normally.

Source files
------------

// File: rtl/mem_group_requester.sv
// Group read requester: issues 1..LANES line reads per group on TX_RD and reassembles the
// in-order RX_RD responses into one tagged, lane-masked bundle per group.
module mem_group_requester #(
  parameter int unsigned ADDR_WIDTH = 58,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned LANES      = 2,
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned MAX_GROUPS = 8,
  localparam int unsigned LW        = $clog2(LANES + 1),
  localparam int unsigned CW        = $clog2(MAX_GROUPS + 1)
) (
  input  logic                        CLK_400M,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        grp_valid,
  output logic                        grp_ready,
  input  logic [LANES*ADDR_WIDTH-1:0] grp_addr,
  input  logic [LW-1:0]               grp_lanes,
  input  logic [TAG_WIDTH-1:0]        grp_tag,
  input  logic                        spl_tx_rd_almostfull,
  output logic                        cor_tx_rd_valid,
  output logic [ADDR_WIDTH-1:0]       cor_tx_rd_addr,
  input  logic                        io_rx_rd_valid,
  input  logic [DATA_WIDTH-1:0]       io_rx_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_mask,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic [CW-1:0]               groups_inflight,
  output logic                        err_overflow
);

  localparam int unsigned RDEPTH = MAX_GROUPS * LANES;
  localparam int unsigned RCW    = $clog2(RDEPTH + 1);
  localparam int unsigned RPW    = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int unsigned TPW    = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;
  localparam int unsigned IW     = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  // Issue side
  logic [0:0]            state_q;
  logic [LW-1:0]         li_q;
  logic [LW-1:0]         lanes_q;
  logic [ADDR_WIDTH-1:0] addr_q [LANES];
  logic [LW-1:0]         lanes_clamped;
  logic                  grp_accept;

  // Tracker FIFO: per-group lane count and tag, consumed by the assembler
  logic [LW-1:0]         trk_lanes [MAX_GROUPS];
  logic [TAG_WIDTH-1:0]  trk_tag   [MAX_GROUPS];
  logic [TPW-1:0]        trk_wptr_q, trk_rptr_q;
  logic [CW-1:0]         trk_cnt_q;

  // Response FIFO
  logic [DATA_WIDTH-1:0] resp_mem [RDEPTH];
  logic [RPW-1:0]        resp_wptr_q, resp_rptr_q;
  logic [RCW-1:0]        resp_cnt_q;
  logic [RCW-1:0]        outst_q;
  logic                  resp_full;
  logic                  resp_write;

  // Assembler
  logic [DATA_WIDTH-1:0]       slots_q    [LANES];
  logic [DATA_WIDTH-1:0]       slots_next [LANES];
  logic [LW-1:0]               ai_q, ai_next;
  logic [LW-1:0]               head_lanes;
  logic [TAG_WIDTH-1:0]        head_tag;
  logic                        pop_resp, bundle_free, load, consume;
  logic [LANES-1:0]            mask_next;
  logic [LANES*DATA_WIDTH-1:0] data_next;

  assign lanes_clamped = (grp_lanes == '0 || grp_lanes > LW'(LANES)) ? LW'(LANES) : grp_lanes;
  assign grp_ready     = reset_n & ~clear & (state_q == StIdle) &
                         (groups_inflight < CW'(MAX_GROUPS));
  assign grp_accept    = grp_valid & grp_ready;

  // A response with nothing outstanding or no room is dropped and flagged.
  assign resp_full  = (resp_cnt_q == RCW'(RDEPTH));
  assign resp_write = io_rx_rd_valid & ~resp_full & (outst_q != '0) & ~clear;

  assign head_lanes  = trk_lanes[trk_rptr_q];
  assign head_tag    = trk_tag[trk_rptr_q];
  assign pop_resp    = (resp_cnt_q != '0) & (trk_cnt_q != '0) & (ai_q < head_lanes);
  assign ai_next     = ai_q + LW'(pop_resp);
  assign bundle_free = ~out_valid | out_ready;
  assign consume     = out_valid & out_ready;
  // The last lane's data is taken straight from the FIFO head so the bundle loads on its pop.
  assign load        = (trk_cnt_q != '0) & (ai_next == head_lanes) & bundle_free;

  always_comb begin
    slots_next = slots_q;
    if (pop_resp) begin
      slots_next[IW'(ai_q)] = resp_mem[resp_rptr_q];
    end
    mask_next = '0;
    data_next = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (LW'(i) < head_lanes) begin
        mask_next[i]                         = 1'b1;
        data_next[i*DATA_WIDTH +: DATA_WIDTH] = slots_next[i];
      end
    end
  end

  // Storage without reset; validity is tracked by the counters below.
  always_ff @(posedge CLK_400M) begin
    if (grp_accept) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        addr_q[i] <= grp_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      trk_lanes[trk_wptr_q] <= lanes_clamped;
      trk_tag[trk_wptr_q]   <= grp_tag;
    end
    if (resp_write) begin
      resp_mem[resp_wptr_q] <= io_rx_data;
    end
    slots_q <= slots_next;
  end

  always_ff @(posedge CLK_400M or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      li_q            <= '0;
      lanes_q         <= '0;
      cor_tx_rd_valid <= 1'b0;
      cor_tx_rd_addr  <= '0;
      trk_wptr_q      <= '0;
      trk_rptr_q      <= '0;
      trk_cnt_q       <= '0;
      resp_wptr_q     <= '0;
      resp_rptr_q     <= '0;
      resp_cnt_q      <= '0;
      outst_q         <= '0;
      ai_q            <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_mask        <= '0;
      out_tag         <= '0;
      groups_inflight <= '0;
      err_overflow    <= 1'b0;
    end else if (clear) begin
      state_q         <= StIdle;
      li_q            <= '0;
      lanes_q         <= '0;
      cor_tx_rd_valid <= 1'b0;
      cor_tx_rd_addr  <= '0;
      trk_wptr_q      <= '0;
      trk_rptr_q      <= '0;
      trk_cnt_q       <= '0;
      resp_wptr_q     <= '0;
      resp_rptr_q     <= '0;
      resp_cnt_q      <= '0;
      outst_q         <= '0;
      ai_q            <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_mask        <= '0;
      out_tag         <= '0;
      groups_inflight <= '0;
      err_overflow    <= 1'b0;
    end else begin
      cor_tx_rd_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grp_accept) begin
            state_q <= StIssue;
            li_q    <= '0;
            lanes_q <= lanes_clamped;
          end
        end
        StIssue: begin
          if (!spl_tx_rd_almostfull) begin
            cor_tx_rd_valid <= 1'b1;
            cor_tx_rd_addr  <= addr_q[IW'(li_q)];
            li_q            <= li_q + LW'(1);
            if (li_q == lanes_q - LW'(1)) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (grp_accept) begin
        trk_wptr_q <= (trk_wptr_q == TPW'(MAX_GROUPS - 1)) ? '0 : trk_wptr_q + TPW'(1);
      end
      if (load) begin
        trk_rptr_q <= (trk_rptr_q == TPW'(MAX_GROUPS - 1)) ? '0 : trk_rptr_q + TPW'(1);
      end
      trk_cnt_q       <= trk_cnt_q + CW'(grp_accept) - CW'(load);
      groups_inflight <= groups_inflight + CW'(grp_accept) - CW'(consume);

      if (resp_write) begin
        resp_wptr_q <= (resp_wptr_q == RPW'(RDEPTH - 1)) ? '0 : resp_wptr_q + RPW'(1);
      end
      if (pop_resp) begin
        resp_rptr_q <= (resp_rptr_q == RPW'(RDEPTH - 1)) ? '0 : resp_rptr_q + RPW'(1);
      end
      resp_cnt_q <= resp_cnt_q + RCW'(resp_write) - RCW'(pop_resp);
      outst_q    <= outst_q + RCW'(cor_tx_rd_valid) - RCW'(resp_write);
      if (io_rx_rd_valid && !resp_write) begin
        err_overflow <= 1'b1;
      end

      ai_q <= load ? '0 : ai_next;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= data_next;
        out_mask  <= mask_next;
        out_tag   <= head_tag;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_group_requester.sv
// Scoreboard bench for mem_group_requester: stimulus pushes expected requests and bundles,
// a negedge monitor pops and compares, a responder returns lines for observed requests.
`timescale 1ns/100ps
module tb_mem_group_requester;

  typedef struct {
    logic [1023:0] data;
    logic [1:0]    mask;
    logic [5:0]    tag;
  } bundle_t;

  logic          clk;
  logic          reset_n;
  logic          clear;
  logic          grp_valid;
  logic          grp_ready;
  logic [115:0]  grp_addr;
  logic [1:0]    grp_lanes;
  logic [5:0]    grp_tag;
  logic          spl;
  logic          cor_tx_rd_valid;
  logic [57:0]   cor_tx_rd_addr;
  logic          io_rx_rd_valid;
  logic [511:0]  io_rx_data;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] out_data;
  logic [1:0]    out_mask;
  logic [5:0]    out_tag;
  logic [3:0]    groups_inflight;
  logic          err_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rsp_cyc    = 0;
  int last_bundle_cyc = 0;
  int inject  = 0;
  bit rsp_en  = 1'b1;

  logic [57:0]  exp_addr[$];
  bundle_t      exp_bundle[$];
  logic [511:0] rsp_q[$];
  int           req_cyc[$];

  mem_group_requester dut (
    .CLK_400M             (clk),
    .reset_n              (reset_n),
    .clear                (clear),
    .grp_valid            (grp_valid),
    .grp_ready            (grp_ready),
    .grp_addr             (grp_addr),
    .grp_lanes            (grp_lanes),
    .grp_tag              (grp_tag),
    .spl_tx_rd_almostfull (spl),
    .cor_tx_rd_valid      (cor_tx_rd_valid),
    .cor_tx_rd_addr       (cor_tx_rd_addr),
    .io_rx_rd_valid       (io_rx_rd_valid),
    .io_rx_data           (io_rx_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_mask             (out_mask),
    .out_tag              (out_tag),
    .groups_inflight      (groups_inflight),
    .err_overflow         (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory model contents for a given line address.
  function automatic logic [511:0] line_of(input logic [57:0] a);
    logic [511:0] r;
    r          = '0;
    r[57:0]    = a;
    r[127:70]  = ~a;
    r[511:454] = a ^ 58'h2A5;
    return r;
  endfunction

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitor
  initial forever begin
    @(negedge clk);
    if (cor_tx_rd_valid) begin
      req_cyc.push_back(cyc);
      rsp_q.push_back(line_of(cor_tx_rd_addr));
      if (exp_addr.size() == 0) begin
        fail("req_unexpected");
      end else begin
        check("req_addr", cor_tx_rd_addr, exp_addr.pop_front());
      end
    end
    if (out_valid && out_ready) begin
      last_bundle_cyc = cyc;
      if (exp_bundle.size() == 0) begin
        fail("bundle_unexpected");
      end else begin
        bundle_t b;
        b = exp_bundle.pop_front();
        check("bundle_tag", out_tag, b.tag);
        check("bundle_mask", out_mask, b.mask);
        check("bundle_data", out_data, b.data);
      end
    end
  end

  // Responder
  initial begin
    io_rx_rd_valid = 1'b0;
    io_rx_data     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (inject > 0) begin
        io_rx_rd_valid = 1'b1;
        io_rx_data     = {16{32'hDEAD_BEEF}};
        inject--;
      end else if (rsp_en && rsp_q.size() > 0) begin
        io_rx_rd_valid = 1'b1;
        io_rx_data     = rsp_q.pop_front();
        last_rsp_cyc   = cyc;
      end else begin
        io_rx_rd_valid = 1'b0;
      end
    end
  end

  task automatic send(input logic [57:0] a0, input logic [57:0] a1, input logic [1:0] lanes,
                      input logic [5:0] tag, input logic [1:0] emask);
    bundle_t b;
    bit ok;
    b.data = {(emask[1] ? line_of(a1) : 512'h0), (emask[0] ? line_of(a0) : 512'h0)};
    b.mask = emask;
    b.tag  = tag;
    if (emask[0]) exp_addr.push_back(a0);
    if (emask[1]) exp_addr.push_back(a1);
    exp_bundle.push_back(b);
    grp_addr  = {a1, a0};
    grp_lanes = lanes;
    grp_tag   = tag;
    grp_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    grp_valid = 1'b0;
    if (!ok) fail("send_timeout");
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_addr.size() == 0 && exp_bundle.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; clear = 1'b0; grp_valid = 1'b0; grp_addr = '0; grp_lanes = '0;
    grp_tag = '0; spl = 1'b0; out_ready = 1'b1;
    step(3);
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_tx_valid", cor_tx_rd_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mask", out_mask, 0);
    check("rst_inflight", groups_inflight, 0);
    check("rst_err", err_overflow, 0);
    check("rst_grp_ready", grp_ready, 1);
    step(1);

    // Two lanes, no stall
    req_cyc.delete();
    send(58'h100, 58'h200, 2'd2, 6'd5, 2'b11);
    wait_drain();
    check("t1_req_cnt", req_cyc.size(), 2);
    if (req_cyc.size() >= 2) check("t1_req_gap", req_cyc[1] - req_cyc[0], 1);
    check("t1_latency", last_bundle_cyc - last_rsp_cyc, 2);

    // One lane, then lanes=0 clamped to two
    req_cyc.delete();
    send(58'h40, 58'h999, 2'd1, 6'd9, 2'b01);
    wait_drain();
    check("t2_req_cnt_one", req_cyc.size(), 1);
    req_cyc.delete();
    send(58'h300, 58'h400, 2'd0, 6'd3, 2'b11);
    wait_drain();
    check("t2_req_cnt_zero", req_cyc.size(), 2);

    // almostfull for three cycles after the first request
    req_cyc.delete();
    send(58'h500, 58'h580, 2'd2, 6'd12, 2'b11);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cor_tx_rd_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("t3_first_req_timeout");
    spl = 1'b1;
    repeat (3) @(negedge clk);
    spl = 1'b0;
    wait_drain();
    check("t3_req_cnt", req_cyc.size(), 2);
    if (req_cyc.size() >= 2) check("t3_req_gap", req_cyc[1] - req_cyc[0], 4);

    // Fill all group slots with the consumer stalled
    out_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      send(58'h1000 + 58'(t * 16), 58'h2000 + 58'(t * 16), 2'd2, 6'(t), 2'b11);
    end
    step(40);
    @(negedge clk);
    check("t4_full_ready", grp_ready, 0);
    check("t4_full_inflight", groups_inflight, 8);
    check("t4_held_valid", out_valid, 1);
    check("t4_held_tag", out_tag, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("t4_inflight_7", groups_inflight, 7);
    check("t4_ready_again", grp_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // Unexpected response
    @(negedge clk);
    check("t5_err_before", err_overflow, 0);
    @(posedge clk); #1;
    inject = 1;
    step(4);
    @(negedge clk);
    check("t5_err_set", err_overflow, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_inflight", groups_inflight, 0);
    step(5);
    @(negedge clk);
    check("t5_err_sticky", err_overflow, 1);
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    check("t5_ready_in_clear", grp_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("t5_err_cleared", err_overflow, 0);
    @(posedge clk); #1;

    // clear with reads outstanding
    rsp_en = 1'b0;
    send(58'h600, 58'h700, 2'd2, 6'd7, 2'b11);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_addr.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("t6_req_timeout");
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_bundle.delete();
    rsp_en = 1'b1;
    step(6);
    @(negedge clk);
    check("t6_err_late_rsp", err_overflow, 1);
    check("t6_out_valid", out_valid, 0);
    check("t6_inflight", groups_inflight, 0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("t6_err_cleared", err_overflow, 0);
    @(posedge clk); #1;

    // Asynchronous reset mid-issue with a bundle held
    out_ready = 1'b0;
    send(58'h800, 58'h880, 2'd1, 6'd1, 2'b01);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("t7_valid_timeout");
    @(posedge clk); #1;
    send(58'h900, 58'h980, 2'd2, 6'd2, 2'b11);
    reset_n = 1'b0;
    #1;
    check("t7_rst_out_valid", out_valid, 0);
    check("t7_rst_out_data", out_data, 0);
    check("t7_rst_out_tag", out_tag, 0);
    check("t7_rst_tx_valid", cor_tx_rd_valid, 0);
    check("t7_rst_inflight", groups_inflight, 0);
    check("t7_rst_grp_ready", grp_ready, 0);
    exp_addr.delete();
    exp_bundle.delete();
    rsp_q.delete();
    @(posedge clk); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send(58'hA00, 58'hA80, 2'd2, 6'd33, 2'b11);
    wait_drain();
    check("end_queues", exp_addr.size() + exp_bundle.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
